// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test: FSM state encoding,
// ALU opcode constants and the fixed eight-entry test vector table.
package alu_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    // One test vector: operands, opcode and the result a healthy ALU returns.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp;
    } vec_t;

    // Vector table lookup; the index space is exactly eight entries.
    function automatic vec_t vec_lookup(input logic [2:0] idx);
        vec_t v;
        case (idx)
            3'd0:    v = '{a: 32'd25,         b: 32'd100,        op: OP_ADD,  exp: 32'h0000_007D};
            3'd1:    v = '{a: 32'd333,        b: 32'd1024,       op: OP_SUB,  exp: 32'hFFFF_FD4D};
            3'd2:    v = '{a: 32'h0000_F0F0,  b: 32'h0000_0F0F,  op: OP_AND,  exp: 32'h0000_0000};
            3'd3:    v = '{a: 32'h0000_A0A0,  b: 32'h0000_5F5F,  op: OP_OR,   exp: 32'h0000_FFFF};
            3'd4:    v = '{a: 32'h0000_1212,  b: 32'h0000_3232,  op: OP_XOR,  exp: 32'h0000_2020};
            3'd5:    v = '{a: 32'h0000_2222,  b: 32'h0000_2222,  op: OP_NOR,  exp: 32'hFFFF_DDDD};
            3'd6:    v = '{a: 32'hFFFF_F345,  b: 32'h0000_7354,  op: OP_SLT,  exp: 32'h0000_0001};
            default: v = '{a: 32'hFFFF_F123,  b: 32'h0000_7811,  op: OP_SLTU, exp: 32'h0000_0000};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Combinational vector ROM: a 3-bit index selects operands, opcode and the
// expected ALU result from the shared table.
module alu_bist_rom
    import alu_bist_pkg::*;
(
    input  logic [2:0]  idx_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [2:0]  op_o,
    output logic [31:0] exp_o
);

    vec_t vec;

    // Pure table lookup, no state.
    always_comb begin
        vec   = vec_lookup(idx_i);
        a_o   = vec.a;
        b_o   = vec.b;
        op_o  = vec.op;
        exp_o = vec.exp;
    end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test controller. Walks the eight-entry vector table,
// drives registered operands to the ALU under test, waits SETTLE_CYCLES,
// compares ALUResult/Zero against the expected value and accumulates a
// failure count and the index of the first failing vector.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_VEC       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [2:0]  ALUControl,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_count,
    output logic [2:0]  fail_index
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_IDX    = 3'(NUM_VEC - 1);

    state_t      state_q;
    logic [3:0]  settle_cnt_q;
    logic [2:0]  idx_q;
    logic [31:0] exp_q;

    logic [2:0]  rom_idx;
    logic [31:0] rom_a;
    logic [31:0] rom_b;
    logic [2:0]  rom_op;
    logic [31:0] rom_exp;

    logic        vec_fail;
    logic [3:0]  err_count_d;

    // The ROM is always addressed at the vector to be loaded next: the
    // successor while checking, vector 0 otherwise. The expected value is
    // captured with the operands so the check uses the vector under test.
    assign rom_idx = (state_q == ST_CHECK) ? (idx_q + 3'd1) : 3'd0;

    alu_bist_rom u_rom (
        .idx_i (rom_idx),
        .a_o   (rom_a),
        .b_o   (rom_b),
        .op_o  (rom_op),
        .exp_o (rom_exp)
    );

    // Compare the ALU response for the vector currently applied.
    always_comb begin
        vec_fail    = (ALUResult != exp_q) || (Zero != (exp_q == 32'd0));
        err_count_d = err_count + {3'b000, vec_fail};
    end

    // Sequencer: state, settle counter, index, operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= 4'd0;
            idx_q        <= 3'd0;
            exp_q        <= 32'd0;
            SrcA         <= 32'd0;
            SrcB         <= 32'd0;
            ALUControl   <= 3'b000;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= 4'd0;
            fail_index   <= 3'd0;
        end else begin
            // NOTE: every register here uses <= so all reads in this block
            // see the values from before the edge, regardless of statement order.
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_APPLY;
                        idx_q      <= 3'd0;
                        SrcA       <= rom_a;
                        SrcB       <= rom_b;
                        ALUControl <= rom_op;
                        exp_q      <= rom_exp;
                        err_count  <= 4'd0;
                        fail_index <= 3'd0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end

                ST_APPLY: begin
                    settle_cnt_q <= 4'd0;
                    state_q      <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= 4'd0;
                        state_q      <= ST_CHECK;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end

                ST_CHECK: begin
                    err_count <= err_count_d;
                    // Only the first failure of the run records its index.
                    if (vec_fail && (err_count == 4'd0)) begin
                        fail_index <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count_d == 4'd0);
                    end else begin
                        state_q    <= ST_APPLY;
                        idx_q      <= idx_q + 3'd1;
                        SrcA       <= rom_a;
                        SrcB       <= rom_b;
                        ALUControl <= rom_op;
                        exp_q      <= rom_exp;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist. Two instances: SETTLE_CYCLES=2 with a
// fault-injectable ALU model, and SETTLE_CYCLES=1 with a healthy ALU for
// back-to-back runs. Expected run results are predicted from an independent
// ALU model and queued when a run is started, then popped when done rises.
module tb_alu_bist;

    typedef struct {
        int   done_edge;
        int   err;
        int   fidx;
        logic pass;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   fault_mode = 0;   // 0 healthy, 1 result bit0 stuck-at-1, 2 Zero stuck-at-0

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2;
    logic [31:0] srca1, srcb1, res1, srca2, srcb2, res2;
    logic [2:0]  op1, op2, fidx1, fidx2;
    logic        zero1, zero2, busy1, busy2, done1, done2, pass1, pass2;
    logic [3:0]  err1, err2;

    always #5 clk = ~clk;

    alu_bist #(.SETTLE_CYCLES(2), .NUM_VEC(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .SrcA(srca1), .SrcB(srcb1), .ALUControl(op1),
        .ALUResult(res1), .Zero(zero1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_index(fidx1)
    );

    alu_bist #(.SETTLE_CYCLES(1), .NUM_VEC(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .SrcA(srca2), .SrcB(srcb2), .ALUControl(op2),
        .ALUResult(res2), .Zero(zero2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_index(fidx2)
    );

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a | b);
            3'd6:    return {31'd0, ($signed(a) < $signed(b))};
            default: return {31'd0, (a < b)};
        endcase
    endfunction

    task automatic tv(input int k, output logic [31:0] a, output logic [31:0] b,
                      output logic [2:0] op);
        case (k)
            0: begin a = 32'd25;        b = 32'd100;       op = 3'd0; end
            1: begin a = 32'd333;       b = 32'd1024;      op = 3'd1; end
            2: begin a = 32'h0000F0F0;  b = 32'h00000F0F;  op = 3'd2; end
            3: begin a = 32'h0000A0A0;  b = 32'h00005F5F;  op = 3'd3; end
            4: begin a = 32'h00001212;  b = 32'h00003232;  op = 3'd4; end
            5: begin a = 32'h00002222;  b = 32'h00002222;  op = 3'd5; end
            6: begin a = 32'hFFFFF345;  b = 32'h00007354;  op = 3'd6; end
            default: begin a = 32'hFFFFF123; b = 32'h00007811; op = 3'd7; end
        endcase
    endtask

    // ALU models feeding the two instances.
    always_comb begin
        res1 = ref_alu(srca1, srcb1, op1);
        if (fault_mode == 1) res1[0] = 1'b1;
        zero1 = (fault_mode == 2) ? 1'b0 : (res1 == 32'd0);
    end
    assign res2  = ref_alu(srca2, srcb2, op2);
    assign zero2 = (res2 == 32'd0);

    // Predict a whole run's outcome for a given fault mode and settle length.
    task automatic predict(input int fm, input int s, output exp_t e);
        logic [31:0] a, b, good, bad;
        logic [2:0]  op;
        logic        badz, fl;
        e.err = 0; e.fidx = 0; e.done_edge = 8 * (s + 2);
        for (int k = 0; k < 8; k++) begin
            tv(k, a, b, op);
            good = ref_alu(a, b, op);
            bad  = good;
            if (fm == 1) bad[0] = 1'b1;
            badz = (fm == 2) ? 1'b0 : (bad == 32'd0);
            fl   = (bad != good) || (badz != (good == 32'd0));
            if (fl) begin
                if (e.err == 0) e.fidx = k;
                e.err++;
            end
        end
        e.pass = (e.err == 0);
    endtask

    task automatic check_vec1(input string tag, input int k);
        logic [31:0] a, b;
        logic [2:0]  op;
        tv(k, a, b, op);
        checks++;
        if (srca1 !== a || srcb1 !== b || op1 !== op) begin
            failures++;
            $display("FAIL %s vec%0d operands: got A=%h B=%h op=%0d expected A=%h B=%h op=%0d",
                     tag, k, srca1, srcb1, op1, a, b, op);
        end
    endtask

    // One full run on dut1; optionally pulse start at edge pulse_at mid-run.
    task automatic run_dut1(input string tag, input int fm, input int pulse_at);
        exp_t e, pe;
        int   edge_n;
        fault_mode = fm;
        predict(fm, 2, pe);
        sb.push_back(pe);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        edge_n = 0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL %s start: got busy=%b done=%b expected busy=1 done=0", tag, busy1, done1);
        end
        check_vec1(tag, 0);
        while (done1 !== 1'b1 && edge_n < 200) begin
            if (edge_n == pulse_at - 1) start1 = 1'b1;
            @(negedge clk);
            edge_n++;
            start1 = 1'b0;
            if (done1 !== 1'b1 && (edge_n % 4) == 0 && edge_n < 32) check_vec1(tag, edge_n / 4);
        end
        e = sb.pop_front();
        checks++;
        if (edge_n != e.done_edge) begin
            failures++;
            $display("FAIL %s done_edge: got %0d expected %0d", tag, edge_n, e.done_edge);
        end
        checks++;
        if (err1 !== 4'(e.err) || fidx1 !== 3'(e.fidx) || pass1 !== e.pass || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL %s result: got err=%0d fidx=%0d pass=%b busy=%b expected err=%0d fidx=%0d pass=%b busy=0",
                     tag, err1, fidx1, pass1, busy1, e.err, e.fidx, e.pass);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b1) begin
            failures++;
            $display("FAIL %s done_hold: got %b expected 1", tag, done1);
        end
        check_vec1({tag, "_hold"}, 7);
    endtask

    task automatic check_zero1(input string tag);
        checks++;
        if (srca1 !== 32'd0 || srcb1 !== 32'd0 || op1 !== 3'd0 || busy1 !== 1'b0 ||
            done1 !== 1'b0 || pass1 !== 1'b0 || err1 !== 4'd0 || fidx1 !== 3'd0) begin
            failures++;
            $display("FAIL %s: got A=%h B=%h op=%0d busy=%b done=%b pass=%b err=%0d fidx=%0d expected all zero",
                     tag, srca1, srcb1, op1, busy1, done1, pass1, err1, fidx1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; fault_mode = 0;
        repeat (2) @(negedge clk);
        check_zero1("reset_dut1");
        checks++;
        if (srca2 !== 32'd0 || busy2 !== 1'b0 || done2 !== 1'b0 || err2 !== 4'd0 || fidx2 !== 3'd0) begin
            failures++;
            $display("FAIL reset_dut2: got A=%h busy=%b done=%b err=%0d fidx=%0d expected zero",
                     srca2, busy2, done2, err2, fidx2);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero1("idle_no_start");
    endtask

    task automatic test_pass;          run_dut1("pass", 0, -1);     endtask
    task automatic test_stuck_bit0;    run_dut1("stuck_bit0", 1, -1); endtask
    task automatic test_zero_stuck;    run_dut1("zero_stuck", 2, -1); endtask
    task automatic test_start_ignored; run_dut1("start_mid", 0, 10); endtask

    task automatic test_reset_mid_run;
        fault_mode = 0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero1("reset_mid_run");
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        check_zero1("after_reset_idle");
        run_dut1("after_reset", 0, -1);
    endtask

    task automatic test_back_to_back;
        exp_t e, pe;
        int   edge_n, low;
        predict(0, 1, pe);
        sb.push_back(pe);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk);
        edge_n = 0;
        while (done2 !== 1'b1 && edge_n < 200) begin
            @(negedge clk);
            edge_n++;
        end
        e = sb.pop_front();
        checks++;
        if (edge_n != e.done_edge || pass2 !== e.pass || err2 !== 4'(e.err)) begin
            failures++;
            $display("FAIL b2b_first: got edge=%0d pass=%b err=%0d expected edge=%0d pass=%b err=%0d",
                     edge_n, pass2, err2, e.done_edge, e.pass, e.err);
        end
        for (int r = 0; r < 2; r++) begin
            predict(0, 1, pe);
            sb.push_back(pe);
            @(negedge clk);
            checks++;
            if (done2 !== 1'b0 || busy2 !== 1'b1) begin
                failures++;
                $display("FAIL b2b_restart%0d: got done=%b busy=%b expected done=0 busy=1", r, done2, busy2);
            end
            low = 1;
            while (done2 !== 1'b1 && low < 200) begin
                @(negedge clk);
                if (done2 !== 1'b1) low++;
            end
            e = sb.pop_front();
            checks++;
            if (low != e.done_edge || pass2 !== e.pass || err2 !== 4'(e.err)) begin
                failures++;
                $display("FAIL b2b_run%0d: got low=%0d pass=%b err=%0d expected low=%0d pass=%b err=%0d",
                         r, low, pass2, err2, e.done_edge, e.pass, e.err);
            end
        end
        start2 = 1'b0;
        @(negedge clk);
        checks++;
        if (done2 !== 1'b1 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop: got done=%b busy=%b expected done=1 busy=0", done2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_stuck_bit0();
        test_zero_stuck();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
